rgb_scene_sequencer: RTL and testbench

Controller that sits between the three rotary-encoder value registers and the three PWM `level` inputs of the RGB mixer. In manual mode it passes the encoder values through to the PWMs. It can capture the current encoder colour into one of SCENES preset slots. In run mode it cycles through the presets autonomously, fading linearly between them with a programmable fade rate and dwell time.

---
 rtl/rgb_scene_sequencer_pkg.sv | 18 +
 rtl/rgb_scene_sequencer_fade_channel.sv | 35 +++
 rtl/rgb_scene_sequencer.sv | 168 ++++++++++++++++
 tb/tb_rgb_scene_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_scene_sequencer_pkg.sv
// rgb_scene_sequencer shared types
// state encoding and default widths
package rgb_scene_sequencer_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_SCENES  = 4;
  localparam int DEF_DWELL_W = 16;
  localparam int DEF_DIV_W   = 8;

  localparam int SCENE_IDX_W = $clog2(DEF_SCENES);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    FADE   = 2'd1,
    DWELL  = 2'd2
  } state_t;

endpackage

// File: rtl/rgb_scene_sequencer_fade_channel.sv
// rgb_scene_sequencer single colour channel
// level register stepping by one toward a target
module rgb_scene_sequencer_fade_channel
  import rgb_scene_sequencer_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] target,
  output logic [W-1:0] level,
  output logic         at_target
);

  assign at_target = (level == target);

  // pass-through load wins; otherwise step one unit toward target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else if (load) begin
      level <= load_val;
    end else if (step) begin
      if (level < target) begin
        level <= level + 1'b1;
      end else if (level > target) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_scene_sequencer.sv
// rgb_scene_sequencer top
// preset store, fade/dwell sequencing, manual pass-through
module rgb_scene_sequencer
  import rgb_scene_sequencer_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int SCENES  = DEF_SCENES,
  parameter int DWELL_W = DEF_DWELL_W,
  parameter int DIV_W   = DEF_DIV_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [W-1:0]              enc0,
  input  logic [W-1:0]              enc1,
  input  logic [W-1:0]              enc2,
  input  logic                      store,
  input  logic [$clog2(SCENES)-1:0] store_idx,
  input  logic                      run,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic [DIV_W-1:0]          fade_div,
  output logic [W-1:0]              level0,
  output logic [W-1:0]              level1,
  output logic [W-1:0]              level2,
  output logic [$clog2(SCENES)-1:0] scene_idx,
  output logic                      fading
);

  localparam int IW = $clog2(SCENES);

  logic [W-1:0] slot_r [SCENES];
  logic [W-1:0] slot_g [SCENES];
  logic [W-1:0] slot_b [SCENES];

  state_t             state;
  state_t             state_d;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_d;
  logic [DIV_W-1:0]   presc;
  logic [DIV_W-1:0]   presc_d;
  logic [DWELL_W-1:0] dcnt;
  logic [DWELL_W-1:0] dcnt_d;

  logic [2:0]   at;
  logic         all_at;
  logic         tick;
  logic         load;
  logic         step;
  logic [W-1:0] tgt_r;
  logic [W-1:0] tgt_g;
  logic [W-1:0] tgt_b;

  assign tgt_r  = slot_r[idx];
  assign tgt_g  = slot_g[idx];
  assign tgt_b  = slot_b[idx];
  assign all_at = &at;

  // >= keeps the wrap safe if fade_div shrinks mid-count
  assign tick = (state == FADE) && (presc >= fade_div);
  // dropping run snaps levels to the encoders on the same edge
  assign load = !run;
  assign step = tick && run;

  assign scene_idx = idx;
  assign fading    = (state == FADE);

  // preset register file, writable in any state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SCENES; i++) begin
        slot_r[i] <= '0;
        slot_g[i] <= '0;
        slot_b[i] <= '0;
      end
    end else if (store) begin
      slot_r[store_idx] <= enc0;
      slot_g[store_idx] <= enc1;
      slot_b[store_idx] <= enc2;
    end
  end

  // sequencer state, scene index and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MANUAL;
      idx   <= '0;
      presc <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      presc <= presc_d;
      dcnt  <= dcnt_d;
    end
  end

  // next-state, prescaler and dwell counter decode
  always_comb begin
    state_d = state;
    idx_d   = idx;
    presc_d = '0;
    dcnt_d  = dcnt;
    unique case (state)
      MANUAL: begin
        if (run) begin
          state_d = FADE;
          idx_d   = '0;
        end
      end
      FADE: begin
        if (!run) begin
          state_d = MANUAL;
        end else if (all_at) begin
          state_d = DWELL;
          dcnt_d  = dwell;
        end else if (!tick) begin
          presc_d = presc + 1'b1;
        end
      end
      DWELL: begin
        if (!run) begin
          state_d = MANUAL;
        end else if (dcnt == '0) begin
          state_d = FADE;
          idx_d   = idx + 1'b1;
        end else begin
          dcnt_d = dcnt - 1'b1;
        end
      end
      default: begin
        state_d = MANUAL;
      end
    endcase
  end

  rgb_scene_sequencer_fade_channel #(.W(W)) u_ch0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_val  (enc0),
    .step      (step),
    .target    (tgt_r),
    .level     (level0),
    .at_target (at[0])
  );

  rgb_scene_sequencer_fade_channel #(.W(W)) u_ch1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_val  (enc1),
    .step      (step),
    .target    (tgt_g),
    .level     (level1),
    .at_target (at[1])
  );

  rgb_scene_sequencer_fade_channel #(.W(W)) u_ch2 (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_val  (enc2),
    .step      (step),
    .target    (tgt_b),
    .level     (level2),
    .at_target (at[2])
  );

endmodule

// File: tb/tb_rgb_scene_sequencer.sv
// rgb_scene_sequencer testbench
// manual vector table plus directed fade/dwell sequences
module tb_rgb_scene_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  enc0;
  logic [7:0]  enc1;
  logic [7:0]  enc2;
  logic        store;
  logic [1:0]  store_idx;
  logic        run;
  logic [15:0] dwell;
  logic [7:0]  fade_div;
  logic [7:0]  level0;
  logic [7:0]  level1;
  logic [7:0]  level2;
  logic [1:0]  scene_idx;
  logic        fading;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] x2;
  } vec_t;

  vec_t vt [5];

  always #5 clk = ~clk;

  rgb_scene_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .enc0      (enc0),
    .enc1      (enc1),
    .enc2      (enc2),
    .store     (store),
    .store_idx (store_idx),
    .run       (run),
    .dwell     (dwell),
    .fade_div  (fade_div),
    .level0    (level0),
    .level1    (level1),
    .level2    (level2),
    .scene_idx (scene_idx),
    .fading    (fading)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input int a0, input int a1,
                     input int a2, input int ai,
                     input int af);
    checks++;
    if ({level0, level1, level2, scene_idx, fading}
        !== {a0[7:0], a1[7:0], a2[7:0], ai[1:0], af[0]}) begin
      failures++;
      $display("FAIL %s: got %h/%h/%h idx=%0d fad=%0b want %h/%h/%h idx=%0d fad=%0b",
               nm, level0, level1, level2, scene_idx, fading,
               a0[7:0], a1[7:0], a2[7:0], ai[1:0], af[0]);
    end
  endtask

  initial begin
    vt[0] = '{8'h40, 8'h41, 8'h42, 8'h40, 8'h41, 8'h42};
    vt[1] = '{8'h00, 8'hFF, 8'h80, 8'h00, 8'hFF, 8'h80};
    vt[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vt[3] = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56};
    vt[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    reset     = 1'b0;
    enc0      = 8'h00;
    enc1      = 8'h00;
    enc2      = 8'h00;
    store     = 1'b0;
    store_idx = 2'd0;
    run       = 1'b0;
    dwell     = 16'd3;
    fade_div  = 8'd0;
    #1;
    chk("rst_init", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // manual pass-through table
    for (int i = 0; i < 5; i++) begin
      enc0 = vt[i].e0;
      enc1 = vt[i].e1;
      enc2 = vt[i].e2;
      tick();
      chk($sformatf("manual%0d", i),
          vt[i].x0, vt[i].x1, vt[i].x2, 0, 0);
    end

    // preload slots 1..3 while in manual
    store = 1'b1;
    store_idx = 2'd1;
    enc0 = 8'h10; enc1 = 8'h20; enc2 = 8'h2F;
    tick();
    chk("store1", 'h10, 'h20, 'h2F, 0, 0);
    store_idx = 2'd2;
    enc2 = 8'h2C;
    tick();
    store_idx = 2'd3;
    tick();
    store = 1'b0;
    enc0 = 8'h00; enc1 = 8'h00; enc2 = 8'h00;
    tick();
    chk("zero", 0, 0, 0, 0, 0);

    // store slot0 and start run in the same cycle
    enc0 = 8'h10; enc1 = 8'h20; enc2 = 8'h30;
    store = 1'b1;
    store_idx = 2'd0;
    run = 1'b1;
    tick();
    chk("run_entry", 0, 0, 0, 0, 1);
    store = 1'b0;
    enc0 = 8'h77; enc1 = 8'h77; enc2 = 8'h77;

    for (int k = 1; k <= 48; k++) begin
      tick();
      chk($sformatf("fade0_%0d", k),
          (k < 'h10) ? k : 'h10,
          (k < 'h20) ? k : 'h20,
          k, 0, 1);
    end

    for (int d = 0; d < 4; d++) begin
      tick();
      chk($sformatf("dwell0_%0d", d), 'h10, 'h20, 'h30, 0, 0);
    end
    tick();
    chk("adv1", 'h10, 'h20, 'h30, 1, 1);
    tick();
    chk("step1", 'h10, 'h20, 'h2F, 1, 1);
    tick();
    chk("dwell1_0", 'h10, 'h20, 'h2F, 1, 0);
    fade_div = 8'd2;
    for (int d = 1; d < 4; d++) begin
      tick();
      chk($sformatf("dwell1_%0d", d), 'h10, 'h20, 'h2F, 1, 0);
    end
    tick();
    chk("adv2", 'h10, 'h20, 'h2F, 2, 1);

    // prescaled down-fade
    for (int j = 1; j <= 9; j++) begin
      tick();
      chk($sformatf("down2_%0d", j), 'h10, 'h20, 'h2F - j / 3, 2, 1);
    end
    for (int d = 0; d < 4; d++) begin
      tick();
      chk($sformatf("dwell2_%0d", d), 'h10, 'h20, 'h2C, 2, 0);
    end
    tick();
    chk("adv3", 'h10, 'h20, 'h2C, 3, 1);
    for (int d = 0; d < 4; d++) begin
      tick();
      chk($sformatf("dwell3_%0d", d), 'h10, 'h20, 'h2C, 3, 0);
    end
    tick();
    chk("wrap0", 'h10, 'h20, 'h2C, 0, 1);

    // live store to active slot redirects the fade
    for (int j = 1; j <= 18; j++) begin
      if (j == 4) begin
        store = 1'b1;
        store_idx = 2'd0;
        enc0 = 8'h10; enc1 = 8'h20; enc2 = 8'h28;
      end
      tick();
      store = 1'b0;
      chk($sformatf("redir_%0d", j), 'h10, 'h20,
          (j <= 3) ? 'h2C + j / 3 : 'h2D - (j - 3) / 3, 0, 1);
    end
    for (int d = 0; d < 4; d++) begin
      tick();
      chk($sformatf("dwell0b_%0d", d), 'h10, 'h20, 'h28, 0, 0);
    end
    tick();
    chk("adv1b", 'h10, 'h20, 'h28, 1, 1);
    tick();
    tick();
    chk("fade1b", 'h10, 'h20, 'h28, 1, 1);

    // run drop mid-fade
    run = 1'b0;
    enc0 = 8'hAA; enc1 = 8'hBB; enc2 = 8'hCC;
    tick();
    chk("drop", 'hAA, 'hBB, 'hCC, 1, 0);
    tick();
    chk("drop_hold", 'hAA, 'hBB, 'hCC, 1, 0);

    // async reset mid-run
    enc0 = 8'h55; enc1 = 8'h55; enc2 = 8'h55;
    tick();
    chk("pre55", 'h55, 'h55, 'h55, 1, 0);
    fade_div = 8'd0;
    run = 1'b1;
    tick();
    chk("rerun", 'h55, 'h55, 'h55, 0, 1);
    tick();
    chk("rerun_step", 'h54, 'h54, 'h54, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", 0, 0, 0, 0, 0);
    run = 1'b0;
    enc0 = 8'h40; enc1 = 8'h41; enc2 = 8'h42;
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst", 'h40, 'h41, 'h42, 0, 0);

    // slots were cleared by reset: fade heads to zero
    run = 1'b1;
    tick();
    chk("clr_entry", 'h40, 'h41, 'h42, 0, 1);
    tick();
    chk("clr_fade", 'h3F, 'h40, 'h41, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
